// File: rtl/sync_fifo_mp.sv
// sync_fifo_mp: multi-lane synchronous FIFO with contiguous per-lane requests and pointer overwrite.
// Defining SYNC_FIFO_MP_ALMOST_FULL_EN enables the almost_full compare; otherwise almost_full is tied to 0.
module sync_fifo_mp #(
   parameter int DEPTH      = 8,
   parameter int WIDTH      = 8,
   parameter int PTR_WIDTH  = $clog2(DEPTH) + 1,
   parameter int W_PORTS    = 2,
   parameter int R_PORTS    = 2,
   parameter int RESET_MODE = 0,
   parameter int AF_THRESH  = DEPTH - 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [W_PORTS-1:0]         w_en,
   input  logic [W_PORTS*WIDTH-1:0]   din,
   input  logic [R_PORTS-1:0]         r_en,
   output logic [R_PORTS*WIDTH-1:0]   dout,
   output logic [R_PORTS-1:0]         dout_valid,
   output logic [PTR_WIDTH-1:0]       w_ptr,
   output logic [PTR_WIDTH-1:0]       r_ptr,
   output logic [PTR_WIDTH-1:0]       count,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       w_fail,
   output logic                       r_fail,
   input  logic                       change_w_ptr_en,
   input  logic                       change_r_ptr_en,
   input  logic [PTR_WIDTH-1:0]       change_w_ptr_value,
   input  logic [PTR_WIDTH-1:0]       change_r_ptr_value
);
   localparam int AW = $clog2(DEPTH);

   if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || PTR_WIDTH != AW + 1 ||
       W_PORTS < 1 || W_PORTS > 4 || R_PORTS < 1 || R_PORTS > 4 ||
       AF_THRESH < 0 || AF_THRESH > DEPTH) begin : g_bad_params
      $error("sync_fifo_mp: illegal parameter combination");
   end

   logic [WIDTH-1:0]         r_mem [DEPTH];
   logic [PTR_WIDTH-1:0]     r_wp;
   logic [PTR_WIDTH-1:0]     r_rp;
   logic [R_PORTS*WIDTH-1:0] r_dout;
   logic [R_PORTS-1:0]       r_dv;
   logic                     r_wf;
   logic                     r_rf;
   logic [PTR_WIDTH-1:0]     w_count;
   logic [PTR_WIDTH-1:0]     w_wn;
   logic [PTR_WIDTH-1:0]     w_rn;
   logic                     w_wok;
   logic                     w_rok;

   assign w_count    = r_wp - r_rp;
   assign count      = w_count;
   assign full       = w_count == PTR_WIDTH'(DEPTH);
   assign empty      = w_count == '0;
   assign w_ptr      = r_wp;
   assign r_ptr      = r_rp;
   assign dout       = r_dout;
   assign dout_valid = r_dv;
   assign w_fail     = r_wf;
   assign r_fail     = r_rf;

`ifdef SYNC_FIFO_MP_ALMOST_FULL_EN
   assign almost_full = w_count >= PTR_WIDTH'(AF_THRESH);
`else
   assign almost_full = 1'b0;
`endif

   // Lane counts and acceptance: requests must be contiguous from lane 0 and fit pre-edge occupancy
   always_comb begin
      w_wn = '0;
      w_rn = '0;
      for (int i = 0; i < W_PORTS; i++) w_wn = w_wn + PTR_WIDTH'(w_en[i]);
      for (int i = 0; i < R_PORTS; i++) w_rn = w_rn + PTR_WIDTH'(r_en[i]);
      w_wok = ((w_en & (w_en + W_PORTS'(1))) == '0) && (w_wn <= PTR_WIDTH'(DEPTH) - w_count);
      w_rok = ((r_en & (r_en + R_PORTS'(1))) == '0) && (w_rn <= w_count);
   end

   // Storage: cleared on reset only when RESET_MODE is 1; accepted lanes land at consecutive addresses
   always_ff @(posedge clk) begin
      if (reset) begin
         if (RESET_MODE == 1)
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (!change_w_ptr_en && w_wok) begin
         for (int i = 0; i < W_PORTS; i++)
            if (w_en[i]) r_mem[AW'(r_wp + PTR_WIDTH'(i))] <= din[(W_PORTS-1-i)*WIDTH +: WIDTH];
      end
   end

   // Pointers, reject pulses and registered read data; overwrite strobes suppress same-cycle transfers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wp   <= '0;
         r_rp   <= '0;
         r_wf   <= 1'b0;
         r_rf   <= 1'b0;
         r_dv   <= '0;
         r_dout <= '0;
      end else begin
         r_wp <= change_w_ptr_en ? change_w_ptr_value : w_wok ? r_wp + w_wn : r_wp;
         r_rp <= change_r_ptr_en ? change_r_ptr_value : w_rok ? r_rp + w_rn : r_rp;
         r_wf <= |w_en && !change_w_ptr_en && !w_wok;
         r_rf <= |r_en && !change_r_ptr_en && !w_rok;
         r_dv <= (!change_r_ptr_en && w_rok) ? r_en : '0;
         for (int i = 0; i < R_PORTS; i++)
            if (!change_r_ptr_en && w_rok && r_en[i])
               r_dout[(R_PORTS-1-i)*WIDTH +: WIDTH] <= r_mem[AW'(r_rp + PTR_WIDTH'(i))];
      end
   end
endmodule

// File: doc/sync_fifo_mp.md
SYNC_FIFO_MP -- requirements
Module: sync_fifo_mp

Interface
REQ-001 Parameter DEPTH, default 8, number of entries; SHALL be a power of two, at least 4.
REQ-002 Parameter WIDTH, default 8, bits per entry.
REQ-003 Parameter PTR_WIDTH, default $clog2(DEPTH)+1, pointer width: address bits plus one wrap bit.
REQ-004 Parameter W_PORTS, default 2, write lanes per cycle, range 1..4.
REQ-005 Parameter R_PORTS, default 2, read lanes per cycle, range 1..4.
REQ-006 Parameter RESET_MODE, default 0: 0 resets pointers and flags only; 1 additionally clears storage to 0.
REQ-007 Parameter AF_THRESH, default DEPTH-2, almost-full occupancy threshold.
REQ-008 Ports:
 clk  in  1  clock; one clock domain only
 reset  in  1  synchronous, active-high reset
 w_en  in  W_PORTS  per-lane write request
 din  in  W_PORTS*WIDTH  write data, lane 0 in the most-significant slice
 r_en  in  R_PORTS  per-lane read request
 dout  out  R_PORTS*WIDTH  registered read data, lane 0 in the most-significant slice
 dout_valid  out  R_PORTS  per-lane dout qualifier
 w_ptr, r_ptr  out  PTR_WIDTH  current write and read pointers
 count  out  PTR_WIDTH  occupancy, 0..DEPTH
 full, empty, almost_full  out  1  status flags
 w_fail, r_fail  out  1  registered request-rejected pulses
 change_w_ptr_en, change_r_ptr_en  in  1  pointer overwrite strobes
 change_w_ptr_value, change_r_ptr_value  in  PTR_WIDTH  overwrite values

Function
REQ-009 The block SHALL derive count = w_ptr - r_ptr modulo 2^PTR_WIDTH, with full = (count==DEPTH) and empty = (count==0); all three are combinational from the registered pointers.
REQ-010 A lane request SHALL be legal only when contiguous from lane 0; a request with a set bit above a clear bit SHALL be rejected whole.
REQ-011 A write of n = popcount(w_en) lanes SHALL be accepted only if legal and n <= DEPTH-count, evaluated on pre-edge state; otherwise no lane is written, w_ptr is held and w_fail pulses high for one cycle.
REQ-012 An accepted write SHALL store lane i at address (w_ptr+i) mod DEPTH and advance w_ptr by n at the edge.
REQ-013 A read of m = popcount(r_en) lanes SHALL be accepted only if legal and m <= count, evaluated on pre-edge state; otherwise r_ptr is held, dout_valid is all-zero next cycle and r_fail pulses high.
REQ-014 An accepted read SHALL present entry (r_ptr+i) on dout lane i with dout_valid[i]=1 one cycle after the request, and advance r_ptr by m; dout SHALL hold its previous value on non-read cycles.
REQ-015 Simultaneous read and write SHALL both be judged against pre-edge count; data written in the same cycle SHALL NOT be readable in that cycle.
REQ-016 Pointers SHALL wrap modulo 2^PTR_WIDTH; the wrap bit distinguishes full from empty.
REQ-017 change_w_ptr_en SHALL load w_ptr with change_w_ptr_value and suppress any same-cycle write without asserting w_fail; change_r_ptr_en SHALL behave likewise for r_ptr and reads.
REQ-018 Pointer overwrite values producing count > DEPTH are illegal; behaviour is then undefined.
REQ-019 w_fail and r_fail SHALL be low whenever no request is made.

Reset
REQ-020 reset SHALL take priority over all other inputs.
REQ-021 While reset is high, the block SHALL drive w_ptr=0, r_ptr=0, count=0, empty=1, full=0, almost_full=0, w_fail=0, r_fail=0, dout_valid=0 and dout=0.
REQ-022 With RESET_MODE=1 reset SHALL clear all storage; with RESET_MODE=0 storage SHALL be retained.
REQ-023 A reset asserted in the middle of a transfer SHALL discard that transfer with no partial pointer update.

Configuration
REQ-024 Macro SYNC_FIFO_MP_ALMOST_FULL_EN: when defined, almost_full SHALL equal (count >= AF_THRESH); when undefined, almost_full SHALL be tied to 0 and the compare logic SHALL be absent.

Verification (DEPTH=8, WIDTH=8, W_PORTS=2, R_PORTS=2)
REQ-025 Four cycles of w_en=11 with din pairs (0,1)..(6,7), then one more 11 -> count=8, full=1, fifth write gives w_fail=1 and w_ptr=8.
REQ-026 From full, r_en=11 for four cycles -> dout pairs (0,1),(2,3),(4,5),(6,7) each one cycle later; empty=1; a fifth read gives r_fail=1 and dout_valid=00.
REQ-027 With count=1, r_en=11 -> r_fail=1 and r_ptr unchanged; with w_en=10 -> w_fail=1 and no write.
REQ-028 With count=4, r_en=11 and w_en=11 in the same cycle -> count stays 4 and both pointers advance by 2.
REQ-029 change_w_ptr_en=1 with value 5 plus w_en=11 -> w_ptr=5, no write, w_fail=0; next change_r_ptr_en=1 with value 5 -> count=0, empty=1.
REQ-030 Fill to 7, then assert reset -> all outputs return to reset values on the next edge; with the macro defined and AF_THRESH=6, almost_full=1 before the reset.
